// File: rtl/conv3x3_window_feeder_pkg.sv
// Shared types and MAC timing constants for the 3x3 window feeder.
package conv3x3_window_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN
  } feeder_state_e;

  localparam int unsigned MAC_LATENCY  = 5;
  localparam int unsigned MAC_TAPS     = 9;
  localparam int unsigned MAC_SKEW_TAP = 5;

endpackage

// File: rtl/conv3x3_window_feeder_if.sv
// Control, pixel stream, MAC operand and result-tag bundle of the window feeder.
interface conv3x3_window_feeder_if #(
  parameter int unsigned A_WIDTH           = 16,
  parameter int unsigned B_WIDTH           = 16,
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned IMG_WIDTH         = 32,
  parameter int unsigned IMG_HEIGHT        = 32
);
  import conv3x3_window_feeder_pkg::*;

  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned COL_W = $clog2(IMG_WIDTH);

  logic                            start;
  logic [ACCUMULATOR_WIDTH-1:0]    bias_in;
  logic                            weight_valid;
  logic [B_WIDTH-1:0]              weight_in;
  logic                            pixel_valid;
  logic                            pixel_ready;
  logic [A_WIDTH-1:0]              pixel_in;
  logic                            mac_valid;
  logic [MAC_TAPS*A_WIDTH-1:0]     a_out;
  logic [MAC_TAPS*B_WIDTH-1:0]     b_out;
  logic [ACCUMULATOR_WIDTH-1:0]    psum_out;
  logic                            result_valid;
  logic [ROW_W-1:0]                result_row;
  logic [COL_W-1:0]                result_col;
  logic                            frame_done;

  // Source / sink side (pixel producer, weight loader, MAC result consumer)
  modport master (
    output start, bias_in, weight_valid, weight_in, pixel_valid, pixel_in,
    input  pixel_ready, mac_valid, a_out, b_out, psum_out,
    input  result_valid, result_row, result_col, frame_done
  );

  // Feeder side
  modport slave (
    input  start, bias_in, weight_valid, weight_in, pixel_valid, pixel_in,
    output pixel_ready, mac_valid, a_out, b_out, psum_out,
    output result_valid, result_row, result_col, frame_done
  );

endinterface

// File: rtl/conv3x3_window_feeder_line_buffer.sv
// One image row of pixels; combinational read and clocked write at the same
// address, so a read in the write cycle returns the previous row's pixel.
module conv3x3_window_feeder_line_buffer #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned IMG_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(IMG_WIDTH)-1:0] addr,
  input  logic [A_WIDTH-1:0]           wdata,
  output logic [A_WIDTH-1:0]           rdata_c
);

  logic [A_WIDTH-1:0] mem [IMG_WIDTH];

  // Row storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/conv3x3_window_feeder.sv
// 3x3 sliding-window builder feeding a 9-tap pipelined MAC, with operand skew
// for the late taps and a result tag line matched to the MAC latency.
module conv3x3_window_feeder
  import conv3x3_window_feeder_pkg::*;
#(
  parameter int unsigned A_WIDTH           = 16,
  parameter int unsigned B_WIDTH           = 16,
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned IMG_WIDTH         = 32,
  parameter int unsigned IMG_HEIGHT        = 32
) (
  input logic                   clk,
  input logic                   arst_in,
  conv3x3_window_feeder_if.slave bus
);

  localparam int unsigned ROW_W   = $clog2(IMG_HEIGHT);
  localparam int unsigned COL_W   = $clog2(IMG_WIDTH);
  localparam int unsigned WCNT_W  = $clog2(MAC_TAPS);
  localparam int unsigned PIPE_D  = MAC_LATENCY - 1;
  localparam int unsigned HI_TAPS = MAC_TAPS - MAC_SKEW_TAP;

  typedef struct packed {
    logic             valid;
    logic             last;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } tag_t;

  feeder_state_e                state;
  logic [ROW_W-1:0]             row;
  logic [COL_W-1:0]             col;
  logic [WCNT_W-1:0]            wcnt;
  logic                         pixel_ready_q;
  logic [ACCUMULATOR_WIDTH-1:0] bias_q;
  logic [B_WIDTH-1:0]           w   [MAC_TAPS];
  logic [A_WIDTH-1:0]           win [MAC_TAPS];
  logic [A_WIDTH-1:0]           hi  [HI_TAPS];
  logic [A_WIDTH-1:0]           lb0_rd_c;
  logic [A_WIDTH-1:0]           lb1_rd_c;
  tag_t                         tag0;
  tag_t [PIPE_D-1:0]            pipe;
  logic                         result_valid_q;
  logic [ROW_W-1:0]             result_row_q;
  logic [COL_W-1:0]             result_col_q;
  logic                         frame_done_q;

  logic accept_c;
  logic last_px_c;
  logic last_col_c;
  logic win_ok_c;

  assign accept_c   = bus.pixel_valid & pixel_ready_q;
  assign last_col_c = (col == COL_W'(IMG_WIDTH - 1));
  assign last_px_c  = last_col_c && (row == ROW_W'(IMG_HEIGHT - 1));
  assign win_ok_c   = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // Frame sequencing: bias capture, weight count, raster position, pixel_ready
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      wcnt          <= '0;
      pixel_ready_q <= 1'b0;
      bias_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bias_q <= bus.bias_in;
            wcnt   <= '0;
            row    <= '0;
            col    <= '0;
            state  <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (bus.weight_valid) begin
            if (wcnt == WCNT_W'(MAC_TAPS - 1)) begin
              wcnt          <= '0;
              pixel_ready_q <= 1'b1;
              state         <= STREAM;
            end else begin
              wcnt <= wcnt + WCNT_W'(1);
            end
          end
        end
        STREAM: begin
          if (accept_c) begin
            if (last_col_c) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
            if (last_px_c) begin
              row           <= '0;
              pixel_ready_q <= 1'b0;
              state         <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (frame_done_q) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Weight registers, loaded one beat per tap during LOAD_W
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      w <= '{default: '0};
    end else if (state == LOAD_W && bus.weight_valid) begin
      w[wcnt] <= bus.weight_in;
    end
  end

  conv3x3_window_feeder_line_buffer #(.A_WIDTH(A_WIDTH), .IMG_WIDTH(IMG_WIDTH)) lb0 (
    .clk     (clk),
    .we      (accept_c),
    .addr    (col),
    .wdata   (bus.pixel_in),
    .rdata_c (lb0_rd_c)
  );

  conv3x3_window_feeder_line_buffer #(.A_WIDTH(A_WIDTH), .IMG_WIDTH(IMG_WIDTH)) lb1 (
    .clk     (clk),
    .we      (accept_c),
    .addr    (col),
    .wdata   (lb0_rd_c),
    .rdata_c (lb1_rd_c)
  );

  // Window shift: columns move left, new right column is {oldest, middle, newest} row
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      win <= '{default: '0};
    end else if (accept_c) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb1_rd_c;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb0_rd_c;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= bus.pixel_in;
    end
  end

  // Late taps trail the window by one cycle so the MAC sees one coherent window
  for (genvar k = 0; k < HI_TAPS; k++) begin : g_skew
    always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
        hi[k] <= '0;
      end else begin
        hi[k] <= win[k + MAC_SKEW_TAP];
      end
    end
  end

  // MAC issue tag and result delay line matched to the MAC pipeline depth
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      tag0           <= '0;
      pipe           <= '0;
      result_valid_q <= 1'b0;
      result_row_q   <= '0;
      result_col_q   <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      tag0.valid     <= accept_c & win_ok_c;
      tag0.last      <= last_px_c;
      tag0.row       <= row - ROW_W'(2);
      tag0.col       <= col - COL_W'(2);
      pipe           <= {pipe[PIPE_D-2:0], tag0};
      result_valid_q <= pipe[PIPE_D-1].valid;
      result_row_q   <= pipe[PIPE_D-1].row;
      result_col_q   <= pipe[PIPE_D-1].col;
      frame_done_q   <= pipe[PIPE_D-1].valid & pipe[PIPE_D-1].last;
    end
  end

  for (genvar k = 0; k < MAC_TAPS; k++) begin : g_taps
    if (k < MAC_SKEW_TAP) begin : g_lo
      assign bus.a_out[k*A_WIDTH +: A_WIDTH] = win[k];
    end else begin : g_hi
      assign bus.a_out[k*A_WIDTH +: A_WIDTH] = hi[k - MAC_SKEW_TAP];
    end
    assign bus.b_out[k*B_WIDTH +: B_WIDTH] = w[k];
  end

  assign bus.pixel_ready  = pixel_ready_q;
  assign bus.mac_valid    = tag0.valid;
  assign bus.psum_out     = bias_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_row   = result_row_q;
  assign bus.result_col   = result_col_q;
  assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv3x3_window_feeder.sv
// Directed bench for the window feeder on a 4x4 frame, with a behavioural
// 9-tap MAC (late taps sampled one cycle after issue, 5-cycle latency).
module tb_conv3x3_window_feeder;

  localparam int unsigned AW  = 16;
  localparam int unsigned BW  = 16;
  localparam int unsigned ACW = 32;
  localparam int unsigned W   = 4;
  localparam int unsigned H   = 4;

  logic clk = 1'b0;
  logic arst_in;
  always #5 clk = ~clk;

  conv3x3_window_feeder_if #(
    .A_WIDTH(AW), .B_WIDTH(BW), .ACCUMULATOR_WIDTH(ACW), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) bus ();

  conv3x3_window_feeder #(
    .A_WIDTH(AW), .B_WIDTH(BW), .ACCUMULATOR_WIDTH(ACW), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk     (clk),
    .arst_in (arst_in),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int stray       = 0;

  typedef struct {
    longint val;
    int     row;
    int     col;
    bit     fd;
    int     lat;
  } res_t;

  res_t   got[$];
  longint inf_val[$];
  int     inf_cyc[$];
  longint pend_lo;
  bit     pend = 1'b0;
  int     pend_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint tap_a(int k);
    logic signed [AW-1:0] t;
    t = AW'(bus.a_out >> (k * AW));
    return longint'(t);
  endfunction

  function automatic longint tap_b(int k);
    logic signed [BW-1:0] t;
    t = BW'(bus.b_out >> (k * BW));
    return longint'(t);
  endfunction

  // Behavioural MAC: taps 0..4 + bias at issue, taps 5..8 one cycle later
  always @(negedge clk) begin
    longint v;
    res_t   r;
    if (arst_in) begin
      pend = 1'b0;
      inf_val.delete();
      inf_cyc.delete();
    end else begin
      if (pend) begin
        v = pend_lo;
        for (int k = 5; k < 9; k++) v += tap_a(k) * tap_b(k);
        inf_val.push_back(v);
        inf_cyc.push_back(pend_cyc);
        pend = 1'b0;
      end
      if (bus.mac_valid) begin
        v = longint'(signed'(bus.psum_out));
        for (int k = 0; k < 5; k++) v += tap_a(k) * tap_b(k);
        pend_lo  = v;
        pend     = 1'b1;
        pend_cyc = cyc;
      end
      if (bus.result_valid) begin
        if (inf_val.size() == 0) begin
          stray++;
        end else begin
          r.val = inf_val.pop_front();
          r.lat = cyc - inf_cyc.pop_front();
          r.row = int'(bus.result_row);
          r.col = int'(bus.result_col);
          r.fd  = bus.frame_done;
          got.push_back(r);
        end
      end else if (bus.frame_done) begin
        stray++;
      end
    end
  end

  // Start pulse then nine weight beats; wsel<0 loads all ones, else only tap wsel = 1
  task automatic load_frame(input int bias, input int wsel);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.bias_in = ACW'(bias);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.weight_valid = 1'b1;
      bus.weight_in    = BW'((wsel < 0 || wsel == k) ? 1 : 0);
      @(negedge clk);
    end
    bus.weight_valid = 1'b0;
  endtask

  // Streams pixel values first..first+count-1, optionally with random valid gaps
  task automatic stream(input int first, input int count, input bit gaps);
    int  sent  = 0;
    int  guard = 0;
    bit  rdy;
    while (sent < count && guard < 400) begin
      if (gaps && $urandom_range(1) == 0) begin
        bus.pixel_valid = 1'b0;
      end else begin
        bus.pixel_valid = 1'b1;
        bus.pixel_in    = AW'(first + sent);
      end
      rdy = bus.pixel_ready;
      @(negedge clk);
      if (bus.pixel_valid && rdy) sent++;
      guard++;
    end
    bus.pixel_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int g = 0;
    while (got.size() < n && g < 60) begin
      @(negedge clk);
      g++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors += 7;
    if (bus.pixel_ready !== 1'b0) begin miscompares++; $display("FAIL reset_pixel_ready: got %0b want 0", bus.pixel_ready); end
    if (bus.mac_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mac_valid: got %0b want 0", bus.mac_valid); end
    if (bus.result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_result_valid: got %0b want 0", bus.result_valid); end
    if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %0b want 0", bus.frame_done); end
    if (bus.a_out !== '0) begin miscompares++; $display("FAIL reset_a_out: got %h want 0", bus.a_out); end
    if (bus.b_out !== '0) begin miscompares++; $display("FAIL reset_b_out: got %h want 0", bus.b_out); end
    if (bus.psum_out !== '0) begin miscompares++; $display("FAIL reset_psum: got %h want 0", bus.psum_out); end
    arst_in = 1'b0;
  endtask

  task automatic test_basic();
    int exp[4];
    exp = '{54, 63, 90, 99};
    load_frame(0, -1);
    stream(1, 16, 1'b0);
    wait_results(4);
    vectors++;
    if (got.size() != 4) begin miscompares++; $display("FAIL basic_count: got %0d want 4", got.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      vectors++;
      if (got[i].val !== longint'(exp[i]) || got[i].row != i / 2 || got[i].col != i % 2 || got[i].fd != (i == 3) || got[i].lat != 5) begin
        miscompares++;
        $display("FAIL basic_res%0d: got val=%0d rc=(%0d,%0d) fd=%0b lat=%0d want val=%0d rc=(%0d,%0d) fd=%0b lat=5",
                 i, got[i].val, got[i].row, got[i].col, got[i].fd, got[i].lat, exp[i], i / 2, i % 2, i == 3);
      end
    end
    got.delete();
  endtask

  task automatic test_bias();
    int exp[4];
    exp = '{154, 163, 190, 199};
    load_frame(100, -1);
    stream(1, 16, 1'b0);
    wait_results(4);
    vectors++;
    if (got.size() != 4) begin miscompares++; $display("FAIL bias_count: got %0d want 4", got.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      vectors++;
      if (got[i].val !== longint'(exp[i]) || got[i].row != i / 2 || got[i].col != i % 2 || got[i].fd != (i == 3)) begin
        miscompares++;
        $display("FAIL bias_res%0d: got val=%0d rc=(%0d,%0d) fd=%0b want val=%0d rc=(%0d,%0d) fd=%0b",
                 i, got[i].val, got[i].row, got[i].col, got[i].fd, exp[i], i / 2, i % 2, i == 3);
      end
    end
    got.delete();
  endtask

  task automatic test_skew();
    int exp[2][4];
    exp[0] = '{11, 12, 15, 16};
    exp[1] = '{1, 2, 5, 6};
    for (int p = 0; p < 2; p++) begin
      load_frame(0, (p == 0) ? 8 : 0);
      stream(1, 16, 1'b0);
      wait_results(4);
      vectors++;
      if (got.size() != 4) begin miscompares++; $display("FAIL skew%0d_count: got %0d want 4", p, got.size()); end
      for (int i = 0; i < 4; i++) if (i < got.size()) begin
        vectors++;
        if (got[i].val !== longint'(exp[p][i]) || got[i].row != i / 2 || got[i].col != i % 2) begin
          miscompares++;
          $display("FAIL skew%0d_res%0d: got val=%0d rc=(%0d,%0d) want val=%0d rc=(%0d,%0d)",
                   p, i, got[i].val, got[i].row, got[i].col, exp[p][i], i / 2, i % 2);
        end
      end
      got.delete();
    end
  endtask

  task automatic test_gaps();
    int exp[4];
    exp = '{54, 63, 90, 99};
    load_frame(0, -1);
    stream(1, 16, 1'b1);
    wait_results(4);
    vectors++;
    if (got.size() != 4) begin miscompares++; $display("FAIL gaps_count: got %0d want 4", got.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      vectors++;
      if (got[i].val !== longint'(exp[i]) || got[i].row != i / 2 || got[i].col != i % 2 || got[i].fd != (i == 3) || got[i].lat != 5) begin
        miscompares++;
        $display("FAIL gaps_res%0d: got val=%0d rc=(%0d,%0d) fd=%0b lat=%0d want val=%0d rc=(%0d,%0d) fd=%0b lat=5",
                 i, got[i].val, got[i].row, got[i].col, got[i].fd, got[i].lat, exp[i], i / 2, i % 2, i == 3);
      end
    end
    got.delete();
  endtask

  task automatic test_ignore();
    int exp[4];
    exp = '{54, 63, 90, 99};
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = AW'(16'h7777);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.bias_in = '0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.weight_valid = 1'b1;
      bus.weight_in    = BW'(1);
      vectors++;
      if (bus.pixel_ready !== 1'b0) begin miscompares++; $display("FAIL ldw_ready%0d: got %0b want 0", k, bus.pixel_ready); end
      @(negedge clk);
    end
    bus.weight_valid = 1'b0;
    bus.pixel_valid  = 1'b0;
    stream(1, 8, 1'b0);
    bus.start   = 1'b1;
    bus.bias_in = ACW'(500);
    @(negedge clk);
    bus.start = 1'b0;
    stream(9, 8, 1'b0);
    wait_results(4);
    vectors++;
    if (got.size() != 4) begin miscompares++; $display("FAIL ignore_count: got %0d want 4", got.size()); end
    foreach (exp[i]) if (i < got.size()) begin
      vectors++;
      if (got[i].val !== longint'(exp[i]) || got[i].fd != (i == 3)) begin
        miscompares++;
        $display("FAIL ignore_res%0d: got val=%0d fd=%0b want val=%0d fd=%0b", i, got[i].val, got[i].fd, exp[i], i == 3);
      end
    end
    got.delete();
  endtask

  task automatic test_abort();
    load_frame(7, -1);
    stream(1, 12, 1'b0);
    #2 arst_in = 1'b1;
    #1;
    vectors += 5;
    if (bus.mac_valid !== 1'b0) begin miscompares++; $display("FAIL abort_mac_valid: got %0b want 0", bus.mac_valid); end
    if (bus.pixel_ready !== 1'b0) begin miscompares++; $display("FAIL abort_pixel_ready: got %0b want 0", bus.pixel_ready); end
    if (bus.a_out !== '0) begin miscompares++; $display("FAIL abort_a_out: got %h want 0", bus.a_out); end
    if (bus.b_out !== '0) begin miscompares++; $display("FAIL abort_b_out: got %h want 0", bus.b_out); end
    if (bus.psum_out !== '0) begin miscompares++; $display("FAIL abort_psum: got %h want 0", bus.psum_out); end
    repeat (2) @(negedge clk);
    arst_in = 1'b0;
    repeat (12) @(negedge clk);
    vectors += 2;
    if (got.size() != 0) begin miscompares++; $display("FAIL abort_results: got %0d want 0", got.size()); end
    if (stray != 0) begin miscompares++; $display("FAIL abort_stray: got %0d want 0", stray); end
    got.delete();
    test_basic();
    vectors++;
    if (stray != 0) begin miscompares++; $display("FAIL final_stray: got %0d want 0", stray); end
  endtask

  initial begin
    arst_in          = 1'b1;
    bus.start        = 1'b0;
    bus.bias_in      = '0;
    bus.weight_valid = 1'b0;
    bus.weight_in    = '0;
    bus.pixel_valid  = 1'b0;
    bus.pixel_in     = '0;
    test_reset();
    test_basic();
    test_bias();
    test_skew();
    test_gaps();
    test_ignore();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
